home_access_ctrl: RTL

//  Sequential access controller in front of the home automation core. Replaces the

---
 rtl/home_access_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/home_access_ctrl.sv
// Strobed code-entry access controller: retry counting, timed lockout with alarm,
// logout, and idle auto-relock when HOME_ACCESS_AUTO_RELOCK_EN is defined.
module home_access_ctrl #(
    parameter logic [3:0] PASSWORD       = 4'b0010,
    parameter int         MAX_TRIES      = 3,
    parameter int         LOCKOUT_CYCLES = 16,
    parameter int         IDLE_TIMEOUT   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pa,
    input  logic       pa_valid,
    input  logic       logout,
    input  logic       activity,
    output logic       unlocked,
    output logic       grant,
    output logic       lockout,
    output logic       alarm,
    output logic [1:0] fail_cnt
);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    localparam logic [1:0] FAIL_LAST = 2'(MAX_TRIES - 1);
    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] fail_q, fail_d;
    logic [7:0] lock_tmr_q, lock_tmr_d;
    logic       grant_d;
    logic       unlocked_q, grant_q, lockout_q, alarm_q;

`ifdef HOME_ACCESS_AUTO_RELOCK_EN
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);
    logic [7:0] idle_tmr_q, idle_tmr_d;
`else
    logic unused_activity_s;
    assign unused_activity_s = activity;
`endif

    // Next-state logic; timers only ever count toward their limit and never wrap.
    always_comb begin
        state_d    = state_q;
        fail_d     = fail_q;
        lock_tmr_d = lock_tmr_q;
        grant_d    = 1'b0;
`ifdef HOME_ACCESS_AUTO_RELOCK_EN
        idle_tmr_d = idle_tmr_q;
`endif
        case (state_q)
            ST_LOCKED: begin
                if (pa_valid) begin
                    if (pa == PASSWORD) begin
                        state_d = ST_UNLOCKED;
                        grant_d = 1'b1;
                        fail_d  = 2'd0;
`ifdef HOME_ACCESS_AUTO_RELOCK_EN
                        idle_tmr_d = 8'd0;
`endif
                    end else if (fail_q >= FAIL_LAST) begin
                        state_d    = ST_LOCKOUT;
                        lock_tmr_d = LOCK_LOAD;
                        fail_d     = 2'd0;
                    end else begin
                        fail_d = fail_q + 2'd1;
                    end
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (lock_tmr_q == 8'd0) begin
                    state_d = ST_LOCKED;
                end else begin
                    lock_tmr_d = lock_tmr_q - 8'd1;
                end
            end
            ST_UNLOCKED: begin
                if (logout) begin
                    state_d = ST_LOCKED;
                end else begin
`ifdef HOME_ACCESS_AUTO_RELOCK_EN
                    if (activity) begin
                        idle_tmr_d = 8'd0;
                    end else if (idle_tmr_q >= IDLE_LAST) begin
                        state_d = ST_LOCKED;
                    end else begin
                        idle_tmr_d = idle_tmr_q + 8'd1;
                    end
`else
                    state_d = ST_UNLOCKED;
`endif
                end
            end
            default: begin
                state_d = ST_LOCKED;
                fail_d  = 2'd0;
            end
        endcase
    end

    // State, timers and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOCKED;
            fail_q     <= 2'd0;
            lock_tmr_q <= 8'd0;
            unlocked_q <= 1'b0;
            grant_q    <= 1'b0;
            lockout_q  <= 1'b0;
            alarm_q    <= 1'b0;
`ifdef HOME_ACCESS_AUTO_RELOCK_EN
            idle_tmr_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            lock_tmr_q <= lock_tmr_d;
            unlocked_q <= (state_d == ST_UNLOCKED);
            grant_q    <= grant_d;
            lockout_q  <= (state_d == ST_LOCKOUT);
            alarm_q    <= (state_d == ST_LOCKOUT);
`ifdef HOME_ACCESS_AUTO_RELOCK_EN
            idle_tmr_q <= idle_tmr_d;
`endif
        end
    end

    assign unlocked = unlocked_q;
    assign grant    = grant_q;
    assign lockout  = lockout_q;
    assign alarm    = alarm_q;
    assign fail_cnt = fail_q;

endmodule
